// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared slot state type, coordinate width and default timing constants
package bomb_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_ARMED = 2'd1,
    SLOT_BLAST = 2'd2
  } slot_state_t;

  localparam int COORD_W          = 11;
  localparam int TILE_BITS_DEF    = 5;
  localparam int FUSE_FRAMES_DEF  = 120;
  localparam int BLAST_FRAMES_DEF = 30;

  // Clear the sub-tile bits so a bomb sits on the tile grid.
  function automatic logic [COORD_W-1:0] tile_snap(input logic [COORD_W-1:0] pos,
                                                   input int tile_bits);
    logic [COORD_W-1:0] mask;
    mask = (COORD_W'(1) << tile_bits) - COORD_W'(1);
    return pos & ~mask;
  endfunction

endpackage

// File: rtl/bomb_slot.sv
// rtl/bomb_slot.sv - one bomb slot: IDLE/ARMED/BLAST FSM, frame counter, tile position
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int FUSE_FRAMES  = FUSE_FRAMES_DEF,
  parameter int BLAST_FRAMES = BLAST_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               alloc,
  input  logic [COORD_W-1:0] alloc_x,
  input  logic [COORD_W-1:0] alloc_y,
  input  logic               detonate,
  output logic               armed,
  output logic               blast,
  output logic               explode,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  localparam logic [7:0] FUSE_LOAD  = 8'(FUSE_FRAMES);
  localparam logic [7:0] BLAST_LOAD = 8'(BLAST_FRAMES);

  slot_state_t        state, state_nxt;
  logic [7:0]         count, count_nxt;
  logic [COORD_W-1:0] x_nxt, y_nxt;
  logic               explode_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SLOT_IDLE;
      count   <= '0;
      x       <= '0;
      y       <= '0;
      explode <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      x       <= x_nxt;
      y       <= y_nxt;
      explode <= explode_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    x_nxt       = x;
    y_nxt       = y;
    explode_nxt = 1'b0;
    case (state)
      SLOT_IDLE: begin
        if (alloc) begin
          state_nxt = SLOT_ARMED;
          count_nxt = FUSE_LOAD;
          x_nxt     = alloc_x;
          y_nxt     = alloc_y;
        end
      end
      SLOT_ARMED: begin
        // Remote detonation overrides the fuse count on the same cycle.
        if (detonate || (tick && count == 8'd1)) begin
          state_nxt   = SLOT_BLAST;
          count_nxt   = BLAST_LOAD;
          explode_nxt = 1'b1;
        end else if (tick) begin
          count_nxt = count - 8'd1;
        end
      end
      SLOT_BLAST: begin
        if (tick) begin
          if (count == 8'd1) begin
            state_nxt = SLOT_IDLE;
            count_nxt = '0;
          end else begin
            count_nxt = count - 8'd1;
          end
        end
      end
      default: begin
        state_nxt = SLOT_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  assign armed = (state == SLOT_ARMED);
  assign blast = (state == SLOT_BLAST);

endmodule

// File: rtl/bomb_slot_scheduler.sv
// rtl/bomb_slot_scheduler.sv - bomb pool allocator with duplicate-tile check and ack/reject
// Optional remote detonation input guarded by BOMB_REMOTE_EN.
module bomb_slot_scheduler
  import bomb_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int FUSE_FRAMES  = FUSE_FRAMES_DEF,
  parameter int BLAST_FRAMES = BLAST_FRAMES_DEF,
  parameter int TILE_BITS    = TILE_BITS_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              startOfFrame,
  input  logic                              dropReq,
  input  logic [COORD_W-1:0]                dropX,
  input  logic [COORD_W-1:0]                dropY,
  output logic                              dropAck,
  output logic                              dropReject,
  output logic [NUM_SLOTS-1:0]              slotArmed,
  output logic [NUM_SLOTS-1:0]              slotBlast,
  output logic [NUM_SLOTS-1:0][COORD_W-1:0] slotX,
  output logic [NUM_SLOTS-1:0][COORD_W-1:0] slotY,
  output logic [NUM_SLOTS-1:0]              explodePulse
`ifdef BOMB_REMOTE_EN
  ,
  input  logic                              detonateReq
`endif
);

  logic detonate;
`ifdef BOMB_REMOTE_EN
  assign detonate = detonateReq;
`else
  assign detonate = 1'b0;
`endif

  logic [COORD_W-1:0]   snap_x, snap_y;
  logic [NUM_SLOTS-1:0] busy, alloc;
  logic                 duplicate, found;

  assign snap_x = tile_snap(dropX, TILE_BITS);
  assign snap_y = tile_snap(dropY, TILE_BITS);

  // Decisions use registered slot state, so a slot finishing its blast this
  // cycle still counts as busy.
  always_comb begin
    busy      = slotArmed | slotBlast;
    duplicate = 1'b0;
    found     = 1'b0;
    alloc     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (busy[i] && slotX[i] == snap_x && slotY[i] == snap_y) duplicate = 1'b1;
      if (!busy[i] && !found) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
    if (!dropReq || duplicate) alloc = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropAck    <= 1'b0;
      dropReject <= 1'b0;
    end else begin
      dropAck    <= dropReq && !duplicate && found;
      dropReject <= dropReq && (duplicate || !found);
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    bomb_slot #(
      .FUSE_FRAMES (FUSE_FRAMES),
      .BLAST_FRAMES(BLAST_FRAMES)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .tick    (startOfFrame),
      .alloc   (alloc[i]),
      .alloc_x (snap_x),
      .alloc_y (snap_y),
      .detonate(detonate),
      .armed   (slotArmed[i]),
      .blast   (slotBlast[i]),
      .explode (explodePulse[i]),
      .x       (slotX[i]),
      .y       (slotY[i])
    );
  end

endmodule

// File: tb/tb_bomb_slot_scheduler.sv
// tb/tb_bomb_slot_scheduler.sv - randomized bench with behavioural pool model and directed anchors
module tb_bomb_slot_scheduler;

  localparam int NS    = 4;
  localparam int FUSE  = 120;
  localparam int BLAST = 30;
  localparam int TB    = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sof = 1'b0, drq = 1'b0, det = 1'b0;
  logic [10:0] dx = '0, dy = '0;
  logic ack, rej;
  logic [NS-1:0] armed, blast, pulse;
  logic [NS-1:0][10:0] sx, sy;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  // Model: 0 idle, 1 armed, 2 blast; frames left in the current phase.
  int m_st[NS];
  int m_cnt[NS];
  int m_x[NS];
  int m_y[NS];
  bit m_pulse[NS];
  bit m_ack, m_rej;

  always #5 clk = ~clk;

  bomb_slot_scheduler #(
    .NUM_SLOTS(NS), .FUSE_FRAMES(FUSE), .BLAST_FRAMES(BLAST), .TILE_BITS(TB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .startOfFrame(sof),
    .dropReq     (drq),
    .dropX       (dx),
    .dropY       (dy),
    .dropAck     (ack),
    .dropReject  (rej),
    .slotArmed   (armed),
    .slotBlast   (blast),
    .slotX       (sx),
    .slotY       (sy),
    .explodePulse(pulse)
`ifdef BOMB_REMOTE_EN
    ,
    .detonateReq (det)
`endif
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_st[i] = 0; m_cnt[i] = 0; m_x[i] = 0; m_y[i] = 0; m_pulse[i] = 0;
    end
    m_ack = 0; m_rej = 0;
  endfunction

  function automatic void model_step();
    int pst[NS];
    int tx, ty, slot;
    bit dup;
    pst = m_st;
    tx = (int'(dx) / 32) * 32;
    ty = (int'(dy) / 32) * 32;
    m_ack = 0; m_rej = 0;
    for (int i = 0; i < NS; i++) begin
      m_pulse[i] = 0;
      if (pst[i] == 1) begin
        if (det || (sof && m_cnt[i] == 1)) begin
          m_st[i] = 2; m_cnt[i] = BLAST; m_pulse[i] = 1;
        end else if (sof) m_cnt[i]--;
      end else if (pst[i] == 2 && sof) begin
        if (m_cnt[i] == 1) begin m_st[i] = 0; m_cnt[i] = 0; end
        else m_cnt[i]--;
      end
    end
    if (drq) begin
      dup = 0; slot = -1;
      for (int i = 0; i < NS; i++)
        if (pst[i] != 0 && m_x[i] == tx && m_y[i] == ty) dup = 1;
      for (int i = NS - 1; i >= 0; i--)
        if (pst[i] == 0) slot = i;
      if (dup || slot < 0) m_rej = 1;
      else begin
        m_ack = 1; m_st[slot] = 1; m_cnt[slot] = FUSE; m_x[slot] = tx; m_y[slot] = ty;
      end
    end
  endfunction

  always @(negedge clk) begin : compare
    logic [NS-1:0] ea, eb, ep;
    logic [NS-1:0][10:0] ex, ey;
    if (chk_en) begin
      for (int i = 0; i < NS; i++) begin
        ea[i] = (m_st[i] == 1);
        eb[i] = (m_st[i] == 2);
        ep[i] = m_pulse[i];
        ex[i] = 11'(m_x[i]);
        ey[i] = 11'(m_y[i]);
      end
      check("slotArmed", armed, ea);
      check("slotBlast", blast, eb);
      check("explodePulse", pulse, ep);
      check("slotX", sx, ex);
      check("slotY", sy, ey);
      check("ack_reject", {ack, rej}, {m_ack, m_rej});
    end
  end

  task automatic step(input bit s, input bit d, input int x, input int y, input bit dt);
    @(negedge clk);
    sof = s; drq = d; dx = 11'(x); dy = 11'(y); det = dt;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) step(1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_flags", {ack, rej, armed, blast, pulse}, 0);
    check("reset_pos", {sx, sy}, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    #3;
    model_reset();
    chk_en = 1'b1;
    do_reset();

    // Single drop, duplicate tile, full fuse and blast lifetime.
    step(0, 1, 100, 70, 0);
    check("drop1_ack", ack, 1);
    check("drop1_armed", armed, 4'b0001);
    check("drop1_x", sx[0], 96);
    check("drop1_y", sy[0], 64);
    step(0, 1, 110, 90, 0);
    check("dup_ack_rej", {ack, rej}, 2'b01);
    check("dup_armed", armed, 4'b0001);
    tick_n(119);
    check("fuse_119_armed", armed, 4'b0001);
    tick_n(1);
    check("explode_pulse", pulse, 4'b0001);
    check("explode_blast", {armed, blast}, 8'b0000_0001);
    step(0, 0, 0, 0, 0);
    check("explode_once", pulse, 0);
    tick_n(29);
    check("blast_29", blast, 4'b0001);
    tick_n(1);
    check("blast_done", {armed, blast}, 0);

    // Staggered drops so slot1 frees while slot0 is still busy.
    do_reset();
    step(0, 1, 0, 0, 0);
    tick_n(60);
    step(0, 1, 32, 0, 0);
    tick_n(90);
    check("stagger_s0_free", {armed, blast}, 8'b0010_0000);
    step(0, 1, 64, 0, 0);
    step(0, 1, 96, 0, 0);
    step(0, 1, 128, 0, 0);
    check("pool_full", armed, 4'b1111);
    step(0, 1, 160, 0, 0);
    check("pool_reject", {ack, rej}, 2'b01);
    tick_n(60);
    check("s1_freed", {armed, blast}, 8'b1101_0000);
    step(0, 1, 192, 0, 0);
    check("s1_realloc", {ack, armed}, 5'b1_1111);
    check("s1_realloc_x", sx[1], 192);

    // Drop coincident with the tick that ends every blast.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 32 * i, 64, 0);
    check("five_drops_last", {ack, rej, armed}, 6'b01_1111);
    tick_n(149);
    check("all_blast", blast, 4'b1111);
    step(1, 1, 160, 64, 0);
    check("coincide_reject", {ack, rej, armed, blast}, 10'b01_0000_0000);
    step(0, 1, 160, 64, 0);
    check("next_cycle_ack", {ack, armed}, 5'b1_0001);

    // Random traffic with a mid-run reset.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      bit dt;
      dt = 1'b0;
`ifdef BOMB_REMOTE_EN
      dt = ($urandom_range(0, 60) == 0);
`endif
      if (n == 2000) do_reset();
      step(bit'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), dt);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
